// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - front-panel button debouncing and run/lap/stop sequencing for the stopwatch

module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    // Synchronize, accept a new level only after it has been stable long enough, then edge-detect the press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_lap,
    input  logic [DATA_W-1:0] count_in,
    output logic              sw_run,
    output logic              sw_clear,
    output logic [DATA_W-1:0] disp_data,
    output logic [3:0]        disp_point,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LAP  = 2'b10,
        ST_STOP = 2'b11
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              clear_next;
    logic              capture;
    logic              start_press;
    logic              lap_press;
    logic [DATA_W-1:0] lap_reg;

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_press)
    );

    // State register, clear pulse register and lap capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            sw_clear <= 1'b0;
            lap_reg  <= '0;
        end else begin
            state    <= state_next;
            sw_clear <= clear_next;
            if (capture) begin
                lap_reg <= count_in;
            end
        end
    end

    // Next-state decode; start has priority so a simultaneous lap press is dropped
    always_comb begin
        state_next = state;
        clear_next = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_press) begin
                    state_next = ST_RUN;
                end else if (lap_press) begin
                    clear_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_press) begin
                    state_next = ST_STOP;
                end else if (lap_press) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_press) begin
                    state_next = ST_STOP;
                end else if (lap_press) begin
                    state_next = ST_RUN;
                end
            end
            ST_STOP: begin
                if (start_press) begin
                    state_next = ST_RUN;
                end else if (lap_press) begin
                    state_next = ST_IDLE;
                    clear_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs: run enable, frozen-vs-live display select and the lap marker point
    always_comb begin
        sw_run     = (state == ST_RUN) || (state == ST_LAP);
        disp_data  = (state == ST_LAP) ? lap_reg : count_in;
        disp_point = (state == ST_LAP) ? 4'b0101 : 4'b0100;
        state_dbg  = state;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a cycle-level reference model

module tb_stopwatch_ctrl;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start;
    logic        btn_lap;
    logic [15:0] count_in;
    logic        sw_run;
    logic        sw_clear;
    logic [15:0] disp_data;
    logic [3:0]  disp_point;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(N), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .count_in   (count_in),
        .sw_run     (sw_run),
        .sw_clear   (sw_clear),
        .disp_data  (disp_data),
        .disp_point (disp_point),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: raw samples delayed two edges, a level is accepted after N
    // consecutive differing samples, a press is seen one edge after acceptance of a high level.
    bit          m_h1 [2];
    bit          m_h2 [2];
    bit          m_deb [2];
    bit          m_rose [2];
    bit          m_p [2];
    int          m_run [2];
    logic [1:0]  m_mode;
    logic [15:0] m_lap;
    bit          m_clear;
    int          m_cnt [2];

    always @(posedge clk) begin : model
        bit raw [2];
        bit s;
        raw[0] = btn_start;
        raw[1] = btn_lap;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0;
                m_rose[i] = 0; m_p[i] = 0; m_run[i] = 0;
            end
            m_mode  = 2'd0;
            m_lap   = 16'h0;
            m_clear = 0;
        end else begin
            m_clear = 0;
            if (m_p[0]) begin
                case (m_mode)
                    2'd0: m_mode = 2'd1;
                    2'd1: m_mode = 2'd3;
                    2'd2: m_mode = 2'd3;
                    default: m_mode = 2'd1;
                endcase
            end else if (m_p[1]) begin
                case (m_mode)
                    2'd0: m_clear = 1;
                    2'd1: begin m_mode = 2'd2; m_lap = count_in; end
                    2'd2: m_mode = 2'd1;
                    default: begin m_mode = 2'd0; m_clear = 1; end
                endcase
            end
            for (int i = 0; i < 2; i++) begin
                if (m_p[i]) m_cnt[i]++;
                m_p[i]    = m_rose[i];
                m_rose[i] = 0;
                s         = m_h2[i];
                m_h2[i]   = m_h1[i];
                m_h1[i]   = raw[i];
                if (s != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == N) begin
                        m_rose[i] = s;
                        m_deb[i]  = s;
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state_dbg", state_dbg, m_mode);
            check("sw_run", sw_run, (m_mode == 2'd1) || (m_mode == 2'd2));
            check("sw_clear", sw_clear, m_clear);
            check("disp_data", disp_data, (m_mode == 2'd2) ? m_lap : count_in);
            check("disp_point", disp_point, (m_mode == 2'd2) ? 4'b0101 : 4'b0100);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        step();
        if (which == 0) btn_start = 1'b1; else btn_lap = 1'b1;
        repeat (12) step();
        if (which == 0) btn_start = 1'b0; else btn_lap = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        count_in  = 16'h0042;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        repeat (2) step();
        check("rst_state", state_dbg, 2'b00);
        check("rst_run", sw_run, 1'b0);
        check("rst_clear", sw_clear, 1'b0);
        check("rst_point", disp_point, 4'b0100);
        check("rst_data", disp_data, 16'h0042);
        reset = 1'b0;

        // 1: single start press, state follows 8 edges after first sample
        step();
        btn_start = 1'b1;
        repeat (7) step();
        check("t1_pre_state", state_dbg, 2'b00);
        step();
        check("t1_state", state_dbg, 2'b01);
        check("t1_run", sw_run, 1'b1);
        repeat (11) step();
        btn_start = 1'b0;
        repeat (12) step();
        check("t1_start_cnt", m_cnt[0], 1);
        check("t1_state_hold", state_dbg, 2'b01);

        // 2: bouncing lap rejected, held lap accepted once
        for (int i = 0; i < 10; i++) begin
            btn_lap = (i % 2 == 0);
            repeat (2) step();
        end
        check("t2_bounce_cnt", m_cnt[1], 0);
        check("t2_bounce_state", state_dbg, 2'b01);
        btn_lap = 1'b1;
        repeat (15) step();
        check("t2_lap_cnt", m_cnt[1], 1);
        check("t2_state", state_dbg, 2'b10);
        check("t2_data", disp_data, 16'h0042);
        btn_lap = 1'b0;
        repeat (12) step();

        // 3: lap freeze and resume
        press(1);
        check("t3_resume", state_dbg, 2'b01);
        count_in = 16'h0123;
        press(1);
        check("t3_lap_state", state_dbg, 2'b10);
        count_in = 16'h0456;
        step();
        check("t3_frozen", disp_data, 16'h0123);
        check("t3_point", disp_point, 4'b0101);
        check("t3_run", sw_run, 1'b1);
        press(1);
        check("t3_live", disp_data, 16'h0456);

        // 4: stop then clear
        press(0);
        check("t4_stop", state_dbg, 2'b11);
        check("t4_run", sw_run, 1'b0);
        step();
        btn_lap = 1'b1;
        repeat (8) step();
        check("t4_clear_hi", sw_clear, 1'b1);
        check("t4_idle", state_dbg, 2'b00);
        check("t4_point", disp_point, 4'b0100);
        step();
        check("t4_clear_lo", sw_clear, 1'b0);
        btn_lap = 1'b0;
        repeat (12) step();

        // 5: simultaneous start and lap in RUN
        press(0);
        count_in = 16'h0789;
        step();
        btn_start = 1'b1;
        btn_lap   = 1'b1;
        repeat (8) step();
        check("t5_state", state_dbg, 2'b11);
        check("t5_clear", sw_clear, 1'b0);
        step();
        check("t5_clear2", sw_clear, 1'b0);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (12) step();
        check("t5_lap_reg", dut.lap_reg, 16'h0123);

        // 6: reset while in LAP
        press(0);
        count_in = 16'h0AAA;
        press(1);
        check("t6_lap", disp_data, 16'h0AAA);
        count_in = 16'h0BBB;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_state", state_dbg, 2'b00);
        check("t6_run", sw_run, 1'b0);
        check("t6_data", disp_data, 16'h0BBB);
        check("t6_lap_reg", dut.lap_reg, 16'h0000);

        // 7: start held across reset gives one fresh press after release
        step();
        btn_start = 1'b1;
        repeat (12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (7) step();
        check("t7_pre", state_dbg, 2'b00);
        step();
        check("t7_run", state_dbg, 2'b01);
        btn_start = 1'b0;
        repeat (12) step();
        check("t7_state_hold", state_dbg, 2'b01);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
